// File: rtl/matrixmult_sequencer_pkg.sv
// Shared types and constants for the matrix-vector operand sequencer.
package matrixmult_sequencer_pkg;

    localparam int unsigned N                = 4;
    localparam int unsigned OP_ADDR_VEC_BASE = 16;
    localparam int unsigned OP_WORDS         = 20;
    localparam int unsigned OP_ADDR_W        = 5;
    localparam int unsigned DATA_W           = 32;
    localparam int unsigned PAIR_W           = $clog2(N * N);
    localparam int unsigned COL_W            = $clog2(N);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StIssue,
        StGap,
        StWaitDone
    } state_e;

    // Column of pair k in row-major order; selects the vector element.
    function automatic logic [COL_W-1:0] pair_col(input logic [PAIR_W-1:0] k);
        return COL_W'(k % PAIR_W'(N));
    endfunction

endpackage

// File: rtl/matrixmult_sequencer_if.sv
// Operand-load, job-control and downstream-operand bundle of the sequencer.
interface matrixmult_sequencer_if;
    import matrixmult_sequencer_pkg::*;

    logic                 wr_en;
    logic [OP_ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0]    wr_data;
    logic                 start;
    logic                 mm_done;
    logic                 mm_reset;
    logic [DATA_W-1:0]    mm_in1;
    logic [DATA_W-1:0]    mm_in2;
    logic                 mm_inputs_ready;
    logic                 busy;
    logic                 job_done;
    logic                 job_err;

    modport master (
        output wr_en, wr_addr, wr_data, start, mm_done,
        input  mm_reset, mm_in1, mm_in2, mm_inputs_ready, busy, job_done, job_err
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start, mm_done,
        output mm_reset, mm_in1, mm_in2, mm_inputs_ready, busy, job_done, job_err
    );

endinterface

// File: rtl/matrixmult_operand_store.sv
// Operand register file: N*N matrix words followed by N vector words.
module matrixmult_operand_store
    import matrixmult_sequencer_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_wr_en,
    input  logic [OP_ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0]    i_wr_data,
    input  logic [PAIR_W-1:0]    i_mat_idx,
    input  logic [COL_W-1:0]     i_vec_idx,
    output logic [DATA_W-1:0]    o_mat_data,
    output logic [DATA_W-1:0]    o_vec_data
);

    logic [DATA_W-1:0]    r_mem [OP_WORDS];
    logic [OP_ADDR_W-1:0] w_mat_addr;
    logic [OP_ADDR_W-1:0] w_vec_addr;

    assign w_mat_addr = OP_ADDR_W'(i_mat_idx);
    assign w_vec_addr = OP_ADDR_W'(OP_ADDR_VEC_BASE) + OP_ADDR_W'(i_vec_idx);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < OP_WORDS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr_en && (i_wr_addr < OP_ADDR_W'(OP_WORDS))) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_mat_data = r_mem[w_mat_addr];
    assign o_vec_data = r_mem[w_vec_addr];

endmodule

// File: rtl/matrixmult_sequencer.sv
// Issues the N*N (matrix, vector) operand pairs of a job to the serial
// multiply/sum/latch stage and reports completion or timeout.
module matrixmult_sequencer
    import matrixmult_sequencer_pkg::*;
#(
    parameter int unsigned ISSUE_GAP = 2,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    matrixmult_sequencer_if.slave io_bus
);

    localparam int unsigned GAP_W  = (ISSUE_GAP > 2) ? $clog2(ISSUE_GAP) : 1;
    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [PAIR_W-1:0] LAST_PAIR = PAIR_W'(N * N - 1);

    state_e              r_state;
    logic [PAIR_W-1:0]   r_pair_idx;
    logic [GAP_W-1:0]    r_gap_cnt;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic                r_mm_reset;
    logic                r_inputs_ready;
    logic                r_busy;
    logic                r_job_done;
    logic                r_job_err;
    logic [DATA_W-1:0]   r_mm_in1;
    logic [DATA_W-1:0]   r_mm_in2;

    logic                w_store_wr_en;
    logic [DATA_W-1:0]   w_mat_data;
    logic [DATA_W-1:0]   w_vec_data;

    // Operands may only change while no job is reading them.
    assign w_store_wr_en = io_bus.wr_en && (r_state == StIdle);

    matrixmult_operand_store u_store (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_wr_en    (w_store_wr_en),
        .i_wr_addr  (io_bus.wr_addr),
        .i_wr_data  (io_bus.wr_data),
        .i_mat_idx  (r_pair_idx),
        .i_vec_idx  (pair_col(r_pair_idx)),
        .o_mat_data (w_mat_data),
        .o_vec_data (w_vec_data)
    );

    // Outputs are registered alongside the state they belong to, so each is
    // loaded on the edge that enters its state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= StIdle;
            r_pair_idx     <= '0;
            r_gap_cnt      <= '0;
            r_wait_cnt     <= '0;
            r_mm_reset     <= 1'b0;
            r_inputs_ready <= 1'b0;
            r_busy         <= 1'b0;
            r_job_done     <= 1'b0;
            r_job_err      <= 1'b0;
            r_mm_in1       <= '0;
            r_mm_in2       <= '0;
        end else begin
            r_mm_reset     <= 1'b0;
            r_inputs_ready <= 1'b0;
            r_job_done     <= 1'b0;
            r_job_err      <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (io_bus.start) begin
                        r_state    <= StClear;
                        r_mm_reset <= 1'b1;
                        r_busy     <= 1'b1;
                        r_pair_idx <= '0;
                    end
                end
                StClear: begin
                    r_state        <= StIssue;
                    r_inputs_ready <= 1'b1;
                    r_mm_in1       <= w_mat_data;
                    r_mm_in2       <= w_vec_data;
                end
                StIssue: begin
                    if (r_pair_idx == LAST_PAIR) begin
                        r_state    <= StWaitDone;
                        r_wait_cnt <= '0;
                    end else begin
                        r_state    <= StGap;
                        r_pair_idx <= r_pair_idx + 1'b1;
                        r_gap_cnt  <= '0;
                    end
                end
                StGap: begin
                    if (r_gap_cnt == GAP_W'(ISSUE_GAP - 2)) begin
                        r_state        <= StIssue;
                        r_inputs_ready <= 1'b1;
                        r_mm_in1       <= w_mat_data;
                        r_mm_in2       <= w_vec_data;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                StWaitDone: begin
                    if (io_bus.mm_done) begin
                        r_state    <= StIdle;
                        r_busy     <= 1'b0;
                        r_job_done <= 1'b1;
                    end else if (r_wait_cnt == WAIT_W'(TIMEOUT)) begin
                        r_state   <= StIdle;
                        r_busy    <= 1'b0;
                        r_job_err <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign io_bus.mm_reset        = r_mm_reset;
    assign io_bus.mm_in1          = r_mm_in1;
    assign io_bus.mm_in2          = r_mm_in2;
    assign io_bus.mm_inputs_ready = r_inputs_ready;
    assign io_bus.busy            = r_busy;
    assign io_bus.job_done        = r_job_done;
    assign io_bus.job_err         = r_job_err;

endmodule

// File: tb/tb_matrixmult_sequencer.sv
// Bench for matrixmult_sequencer: job-timeline model plus a behavioural
// multiply/sum/latch downstream stage.
module tb_matrixmult_sequencer;

    localparam int GAP      = 2;
    localparam int TMO      = 64;
    localparam int NN       = 4;
    localparam int LAST_REL = 2 + GAP * (NN * NN - 1);
    localparam int WAIT_REL = LAST_REL + 1;

    logic clk = 1'b0;
    logic reset = 1'b1;

    matrixmult_sequencer_if bus ();

    matrixmult_sequencer #(
        .ISSUE_GAP (GAP),
        .TIMEOUT   (TMO)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Timeline model state
    logic [31:0] m_store [20];
    logic [31:0] m_mat [16];
    logic [31:0] m_vec [4];
    bit          m_idle = 1'b1;
    bit          m_seen_reset = 1'b0;
    int          m_start = -1000;
    logic        e_mm_reset, e_ready, e_busy, e_done, e_err;
    logic [31:0] e_in1, e_in2;

    // Downstream stage model
    bit          ds_en = 1'b1;
    int          ds_cnt = 0;
    logic [31:0] ds_acc = '0;
    logic [31:0] ds_res [4];
    int          ds_done_at = -1;

    always @(posedge clk) begin
        int c;
        int r;
        int k;
        bit fin_done;
        bit fin_err;
        c = cyc;
        fin_done = 1'b0;
        fin_err = 1'b0;
        if (reset || bus.mm_reset) begin
            ds_cnt = 0;
            ds_acc = '0;
            ds_done_at = -1;
            for (int i = 0; i < 4; i++) ds_res[i] = '0;
        end else if (bus.mm_inputs_ready && ds_cnt < NN * NN) begin
            ds_acc = ds_acc + bus.mm_in1[15:0] * bus.mm_in2[15:0];
            ds_cnt++;
            if (ds_cnt % NN == 0) begin
                ds_res[ds_cnt / NN - 1] = ds_acc;
                ds_acc = '0;
            end
            if (ds_cnt == NN * NN) ds_done_at = c + 3;
        end
        if (reset) begin
            for (int i = 0; i < 20; i++) m_store[i] = '0;
            m_idle = 1'b1;
            m_seen_reset = 1'b1;
            {e_mm_reset, e_ready, e_busy, e_done, e_err} = '0;
            e_in1 = '0;
            e_in2 = '0;
        end else begin
            if (m_idle) begin
                if (bus.wr_en && bus.wr_addr < 5'd20) m_store[bus.wr_addr] = bus.wr_data;
                if (bus.start) begin
                    m_idle = 1'b0;
                    m_start = c;
                    for (int i = 0; i < 16; i++) m_mat[i] = m_store[i];
                    for (int i = 0; i < 4; i++) m_vec[i] = m_store[16 + i];
                end
            end else if (c - m_start >= WAIT_REL) begin
                if (bus.mm_done) begin
                    m_idle = 1'b1;
                    fin_done = 1'b1;
                end else if (c - m_start == WAIT_REL + TMO) begin
                    m_idle = 1'b1;
                    fin_err = 1'b1;
                end
            end
            r = c + 1 - m_start;
            e_busy = !m_idle;
            e_mm_reset = !m_idle && r == 1;
            e_ready = !m_idle && r >= 2 && r <= LAST_REL && ((r - 2) % GAP == 0);
            if (e_ready) begin
                k = (r - 2) / GAP;
                e_in1 = m_mat[k];
                e_in2 = m_vec[k % NN];
            end
            e_done = fin_done;
            e_err = fin_err;
        end
        cyc = cyc + 1;
    end

    always @(negedge clk) bus.mm_done = ds_en && (cyc == ds_done_at);

    // Literal expectations posted by the stimulus, checked by the compare process
    string       lit_name [128];
    int          lit_act [128];
    int          lit_exp [128];
    int          lit_n = 0;
    int          clr_req = 0;

    // Observations of DUT behaviour, cleared on request
    int          o_done_cnt, o_done_cyc, o_err_cnt, o_err_cyc, o_rst_cnt, o_rst_cyc;
    int          o_rdy_cnt, o_rdy_first, o_rdy_last, o_gap_min, o_gap_max, o_busy_cnt;
    bit          o_nz;
    logic [31:0] o_in1 [16];
    logic [31:0] o_in2 [16];

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at cycle %0d", n, act, exp, cyc);
        end
    endtask

    int clr_ack = 0;
    int lit_done = 0;
    always @(negedge clk) begin
        if (clr_ack != clr_req) begin
            clr_ack = clr_req;
            {o_done_cnt, o_done_cyc, o_err_cnt, o_err_cyc, o_rst_cnt, o_rst_cyc} = '0;
            {o_rdy_cnt, o_rdy_first, o_rdy_last, o_busy_cnt} = '0;
            o_gap_min = 1000;
            o_gap_max = 0;
            o_nz = 1'b0;
        end
        if (m_seen_reset) begin
            check("busy", {31'b0, bus.busy}, {31'b0, e_busy});
            check("mm_reset", {31'b0, bus.mm_reset}, {31'b0, e_mm_reset});
            check("inputs_ready", {31'b0, bus.mm_inputs_ready}, {31'b0, e_ready});
            check("mm_in1", bus.mm_in1, e_in1);
            check("mm_in2", bus.mm_in2, e_in2);
            check("job_done", {31'b0, bus.job_done}, {31'b0, e_done});
            check("job_err", {31'b0, bus.job_err}, {31'b0, e_err});
        end
        if (bus.busy) o_busy_cnt++;
        if (bus.job_done) begin o_done_cnt++; o_done_cyc = cyc; end
        if (bus.job_err) begin o_err_cnt++; o_err_cyc = cyc; end
        if (bus.mm_reset) begin o_rst_cnt++; o_rst_cyc = cyc; end
        if (bus.mm_inputs_ready) begin
            if (o_rdy_cnt == 0) o_rdy_first = cyc;
            else begin
                if (cyc - o_rdy_last < o_gap_min) o_gap_min = cyc - o_rdy_last;
                if (cyc - o_rdy_last > o_gap_max) o_gap_max = cyc - o_rdy_last;
            end
            if (o_rdy_cnt < 16) begin
                o_in1[o_rdy_cnt] = bus.mm_in1;
                o_in2[o_rdy_cnt] = bus.mm_in2;
            end
            if (bus.mm_in1 != 0 || bus.mm_in2 != 0) o_nz = 1'b1;
            o_rdy_last = cyc;
            o_rdy_cnt++;
        end
        while (lit_done < lit_n) begin
            check(lit_name[lit_done], lit_act[lit_done], lit_exp[lit_done]);
            lit_done++;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic lit(input string n, input int act, input int exp);
        if (lit_n < 128) begin
            lit_name[lit_n] = n;
            lit_act[lit_n] = act;
            lit_exp[lit_n] = exp;
            lit_n++;
        end
    endtask

    task automatic wr(input int a, input int d);
        bus.wr_en = 1'b1;
        bus.wr_addr = 5'(a);
        bus.wr_data = 32'(d);
        step();
        bus.wr_en = 1'b0;
    endtask

    task automatic go();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic clear_obs();
        clr_req++;
        step();
    endtask

    task automatic wait_end(input string n, input int budget);
        int i;
        i = 0;
        while (o_done_cnt == 0 && o_err_cnt == 0 && i < budget) begin
            step();
            i++;
        end
        if (o_done_cnt == 0 && o_err_cnt == 0) lit(n, 0, 1);
    endtask

    task automatic load_vec(input int v0, input int v1, input int v2, input int v3);
        wr(16, v0);
        wr(17, v1);
        wr(18, v2);
        wr(19, v3);
    endtask

    task automatic check_res(input string n, input int r0, input int r1, input int r2,
                             input int r3);
        lit({n, "_r0"}, int'(ds_res[0]), r0);
        lit({n, "_r1"}, int'(ds_res[1]), r1);
        lit({n, "_r2"}, int'(ds_res[2]), r2);
        lit({n, "_r3"}, int'(ds_res[3]), r3);
    endtask

    int mat_init [16] = '{1, 1, 2, 3, 5, 6, 7, 3, 1, 2, 3, 2, 4, 5, 3, 5};

    initial begin
        bus.wr_en = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.start = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        step();

        // Job 1: base operands, downstream integrated
        for (int i = 0; i < 16; i++) wr(i, mat_init[i]);
        load_vec(2, 5, 3, 1);
        clear_obs();
        go();
        wait_end("t1_wait", 120);
        check_res("t1", 16, 64, 23, 47);
        lit("t1_done_rel", o_done_cyc - m_start, 36);
        lit("t1_pulses", o_rdy_cnt, 16);
        lit("t1_first_rel", o_rdy_first - m_start, 2);
        lit("t1_last_rel", o_rdy_last - m_start, 32);
        lit("t1_gap_min", o_gap_min, 2);
        lit("t1_gap_max", o_gap_max, 2);
        lit("t1_rst_cnt", o_rst_cnt, 1);
        lit("t1_rst_lead", o_rdy_first - o_rst_cyc, 1);
        lit("t1_k6_in1", int'(o_in1[6]), 7);
        lit("t1_k6_in2", int'(o_in2[6]), 3);
        lit("t1_busy_cycles", o_busy_cnt, 35);
        lit("t1_err_cnt", o_err_cnt, 0);

        // Job 2: back-to-back, V=[1,1,1,1], last write shares the start cycle
        clr_req++;
        wr(16, 1);
        wr(17, 1);
        wr(18, 1);
        bus.wr_en = 1'b1;
        bus.wr_addr = 5'd19;
        bus.wr_data = 32'd1;
        bus.start = 1'b1;
        step();
        bus.wr_en = 1'b0;
        bus.start = 1'b0;
        wait_end("t2_wait", 120);
        check_res("t2", 7, 21, 8, 17);
        lit("t2_done_rel", o_done_cyc - m_start, 36);
        lit("t2_rst_cnt", o_rst_cnt, 1);

        // Job 3: write and start while busy are both ignored
        step();
        load_vec(2, 5, 3, 1);
        clear_obs();
        go();
        repeat (4) step();
        bus.start = 1'b1;
        wr(16, 99);
        bus.start = 1'b0;
        wait_end("t3_wait", 120);
        check_res("t3", 16, 64, 23, 47);
        repeat (20) step();
        lit("t3_done_cnt", o_done_cnt, 1);
        lit("t3_busy_cycles", o_busy_cnt, 35);
        lit("t3_rst_cnt", o_rst_cnt, 1);

        // Job 4: no downstream done -> timeout
        ds_en = 1'b0;
        clear_obs();
        go();
        wait_end("t4_wait", 200);
        lit("t4_err_rel", o_err_cyc - m_start, WAIT_REL + TMO + 1);
        lit("t4_err_cnt", o_err_cnt, 1);
        lit("t4_done_cnt", o_done_cnt, 0);
        lit("t4_busy_cycles", o_busy_cnt, WAIT_REL + TMO);
        ds_en = 1'b1;
        step();

        // Job 5: reset at relative cycle 10, then an all-zero job
        clear_obs();
        go();
        repeat (9) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        lit("t5_busy_after_rst", int'(bus.busy), 0);
        lit("t5_rdy_after_rst", int'(bus.mm_inputs_ready), 0);
        repeat (40) step();
        lit("t5_abort_done", o_done_cnt, 0);
        lit("t5_abort_err", o_err_cnt, 0);
        clear_obs();
        go();
        wait_end("t5_wait", 120);
        lit("t5_pulses", o_rdy_cnt, 16);
        lit("t5_nonzero", int'(o_nz), 0);
        lit("t5_res_or", int'(ds_res[0] | ds_res[1] | ds_res[2] | ds_res[3]), 0);
        lit("t5_done_rel", o_done_cyc - m_start, 36);

        repeat (3) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
